xrv_imem_loader: RTL and testbench

- Instruction-memory responder for the fetch side: takes the fetcher's i_addr and returns i_data one cycle later.
- Also owns a byte-stream program-load port, fed by the UART/debug loader, that fills the memory.
- Holds the core in reset through cpu_rstb while a load is in progress.
- Sits between the fetcher, the boot loader and the on-chip instruction RAM.

---
 rtl/xrv_pkg.sv | 19 +
 rtl/xrv_imem_ram.sv | 21 ++
 rtl/xrv_imem_loader.sv | 159 +++++++++++++++
 tb/tb_xrv_imem_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xrv_pkg.sv
// Shared types and constants for the instruction-memory loader slice.
package xrv_pkg;

    localparam logic [31:0] FILL_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE
    } ld_state_e;

    typedef enum logic [1:0] {
        RD_ZERO,
        RD_FILL,
        RD_RAM
    } rd_sel_e;

endpackage

// File: rtl/xrv_imem_ram.sv
// Single-port 2^AW x 32 instruction RAM with registered read.
module xrv_imem_ram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic          we,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/xrv_imem_loader.sv
// Fetch-side instruction memory plus byte-stream program loader.
module xrv_imem_loader
    import xrv_pkg::*;
#(
    parameter int          AW        = 12,
    parameter logic [31:0] FILL_WORD = xrv_pkg::FILL_NOP,
    parameter bit          BOOT_LOAD = 1'b0
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic [31:0]   i_addr,
    output logic [31:0]   i_data,
    input  logic          boot_req,
    input  logic          ld_valid,
    input  logic [7:0]    ld_byte,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          cpu_rstb,
    output logic          load_busy,
    output logic          load_err,
    output logic [AW:0]   word_cnt
);

    localparam logic [AW:0] CAP = {1'b1, {AW{1'b0}}};
    localparam ld_state_e   RST_ST = BOOT_LOAD ? ST_LOAD : ST_RUN;

    ld_state_e   state_q, state_d;
    rd_sel_e     sel_q, sel_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [31:0] asm_q, asm_d;
    logic [AW:0] wcnt_q, wcnt_d;
    logic        err_q, err_d;

    logic          accept;
    logic          full;
    logic          we;
    logic [31:0]   wdata;
    logic [AW-1:0] ram_addr;
    logic [31:0]   rdata;
    logic          unused_addr;

    assign unused_addr = ^i_addr[1:0];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= RST_ST;
            sel_q   <= RD_ZERO;
            bidx_q  <= 2'd0;
            asm_q   <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            bidx_q  <= bidx_d;
            asm_q   <= asm_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bidx_d  = bidx_q;
        asm_d   = asm_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        we      = 1'b0;
        wdata   = asm_q;
        accept  = (state_q == ST_LOAD) && ld_valid;
        full    = (wcnt_q == CAP);
        unique case (state_q)
            ST_RUN: begin
                if (boot_req) begin
                    state_d = ST_LOAD;
                    bidx_d  = 2'd0;
                    asm_d   = '0;
                    wcnt_d  = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    bidx_d = bidx_q + 2'd1;
                    asm_d[{bidx_q, 3'b000} +: 8] = ld_byte;
                    if (bidx_q == 2'd3) begin
                        wdata = {ld_byte, asm_q[23:0]};
                        asm_d = '0;
                        // Past capacity the word is dropped; the stream still drains.
                        if (full) begin
                            err_d = 1'b1;
                        end else begin
                            we     = 1'b1;
                            wcnt_d = wcnt_q + 1'b1;
                        end
                    end
                    if (ld_last) begin
                        state_d = (bidx_q == 2'd3) ? ST_DONE : ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // Unfilled upper lanes are already zero in the assembly register.
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    we     = 1'b1;
                    wcnt_d = wcnt_q + 1'b1;
                end
                asm_d   = '0;
                bidx_d  = 2'd0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        ram_addr = wcnt_q[AW-1:0];
        sel_d    = RD_FILL;
        if (state_q == ST_RUN) begin
            ram_addr = i_addr[AW+1:2];
            if (i_addr[31:AW+2] == '0) begin
                sel_d = RD_RAM;
            end
        end
    end

    always_comb begin
        i_data = '0;
        unique case (sel_q)
            RD_RAM:  i_data = rdata;
            RD_FILL: i_data = FILL_WORD;
            default: i_data = '0;
        endcase
    end

    assign ld_ready  = (state_q == ST_LOAD);
    assign cpu_rstb  = (state_q == ST_RUN);
    assign load_busy = (state_q != ST_RUN);
    assign load_err  = err_q;
    assign word_cnt  = wcnt_q;

    xrv_imem_ram #(
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .wdata (wdata),
        .we    (we),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_xrv_imem_loader.sv
// Bench for xrv_imem_loader: AW=12 run-at-reset and AW=2 boot-load instances.
module tb_xrv_imem_loader;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int M_RUN   = 0;
    localparam int M_LOAD  = 1;
    localparam int M_DRAIN = 2;

    logic        clk;
    logic        rstb_a, rstb_b;
    logic        boot_req [2];
    logic        ld_valid [2];
    logic        ld_last  [2];
    logic [7:0]  ld_byte  [2];
    logic [31:0] i_addr   [2];
    logic [31:0] i_data   [2];
    logic        ld_ready [2];
    logic        cpu_rstb [2];
    logic        load_busy[2];
    logic        load_err [2];
    logic [12:0] wc_a;
    logic [2:0]  wc_b;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    int          mode [2];
    int          cnt  [2];
    int          nb   [2];
    int          wc   [2];
    bit          err  [2];
    logic [31:0] cur  [2];
    logic [31:0] exp_id [2];
    bit          kn   [2];
    logic [31:0] mmem [int];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    xrv_imem_loader #(
        .AW(12), .FILL_WORD(NOP), .BOOT_LOAD(1'b0)
    ) dut_a (
        .clk(clk), .rstb(rstb_a), .i_addr(i_addr[0]), .i_data(i_data[0]),
        .boot_req(boot_req[0]), .ld_valid(ld_valid[0]), .ld_byte(ld_byte[0]),
        .ld_last(ld_last[0]), .ld_ready(ld_ready[0]), .cpu_rstb(cpu_rstb[0]),
        .load_busy(load_busy[0]), .load_err(load_err[0]), .word_cnt(wc_a)
    );

    xrv_imem_loader #(
        .AW(2), .FILL_WORD(NOP), .BOOT_LOAD(1'b1)
    ) dut_b (
        .clk(clk), .rstb(rstb_b), .i_addr(i_addr[1]), .i_data(i_data[1]),
        .boot_req(boot_req[1]), .ld_valid(ld_valid[1]), .ld_byte(ld_byte[1]),
        .ld_last(ld_last[1]), .ld_ready(ld_ready[1]), .cpu_rstb(cpu_rstb[1]),
        .load_busy(load_busy[1]), .load_err(load_err[1]), .word_cnt(wc_b)
    );

    function automatic int aw_of(int k);
        return (k == 0) ? 12 : 2;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset(int k);
        mode[k] = (k == 1) ? M_LOAD : M_RUN;
        cnt[k] = 0; nb[k] = 0; wc[k] = 0; err[k] = 0; cur[k] = '0;
        exp_id[k] = '0; kn[k] = 1;
        for (int i = 0; i < (1 << aw_of(k)); i++) begin
            if (mmem.exists(k * 65536 + i)) mmem.delete(k * 65536 + i);
        end
    endtask

    task automatic put_word(int k);
        if (wc[k] < (1 << aw_of(k))) begin
            mmem[k * 65536 + wc[k]] = cur[k];
            wc[k]++;
        end else begin
            err[k] = 1;
        end
        cur[k] = '0;
    endtask

    task automatic model_step(int k);
        int key;
        logic [31:0] a;
        a = i_addr[k];
        if (mode[k] == M_RUN && (a >> (aw_of(k) + 2)) == 0) begin
            key = k * 65536 + (int'(a >> 2) & ((1 << aw_of(k)) - 1));
            kn[k] = mmem.exists(key);
            if (kn[k]) exp_id[k] = mmem[key];
        end else begin
            exp_id[k] = NOP;
            kn[k] = 1;
        end
        case (mode[k])
            M_RUN: begin
                if (boot_req[k]) begin
                    mode[k] = M_LOAD;
                    nb[k] = 0; wc[k] = 0; err[k] = 0; cur[k] = '0;
                end
            end
            M_LOAD: begin
                if (ld_valid[k]) begin
                    cur[k] = cur[k] | (32'(ld_byte[k]) << (8 * (nb[k] % 4)));
                    nb[k]++;
                    if (nb[k] % 4 == 0) put_word(k);
                    if (ld_last[k]) begin
                        mode[k] = M_DRAIN;
                        cnt[k] = (nb[k] % 4 == 0) ? 1 : 2;
                    end
                end
            end
            default: begin
                if (cnt[k] == 2) put_word(k);
                cnt[k]--;
                if (cnt[k] == 0) mode[k] = M_RUN;
            end
        endcase
    endtask

    always @(posedge clk or negedge rstb_a) begin
        if (!rstb_a) model_reset(0);
        else model_step(0);
    end

    always @(posedge clk or negedge rstb_b) begin
        if (!rstb_b) model_reset(1);
        else model_step(1);
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("cpu_rstb[%0d]", k), cpu_rstb[k], mode[k] == M_RUN);
                chk($sformatf("load_busy[%0d]", k), load_busy[k], mode[k] != M_RUN);
                chk($sformatf("ld_ready[%0d]", k), ld_ready[k], mode[k] == M_LOAD);
                chk($sformatf("load_err[%0d]", k), load_err[k], err[k]);
                chk($sformatf("word_cnt[%0d]", k), (k == 0) ? 32'(wc_a) : 32'(wc_b), wc[k]);
                if (kn[k]) chk($sformatf("i_data[%0d]", k), i_data[k], exp_id[k]);
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(int k, logic [7:0] b, logic last);
        ld_valid[k] = 1'b1; ld_byte[k] = b; ld_last[k] = last;
        cyc(1);
        ld_valid[k] = 1'b0; ld_last[k] = 1'b0;
    endtask

    task automatic send_word(int k, logic [31:0] w, logic last);
        for (int i = 0; i < 4; i++) send(k, w[8*i +: 8], last && (i == 3));
    endtask

    task automatic boot(int k);
        boot_req[k] = 1'b1;
        cyc(1);
        boot_req[k] = 1'b0;
    endtask

    task automatic rd(int k, logic [31:0] a, logic [31:0] exp, string nm);
        i_addr[k] = a;
        cyc(1);
        chk(nm, i_data[k], exp);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            boot_req[k] = 0; ld_valid[k] = 0; ld_last[k] = 0;
            ld_byte[k] = 0; i_addr[k] = 0;
        end
        rstb_a = 1'b0;
        rstb_b = 1'b0;
        cyc(2);
        started = 1;
        chk("rst_idata_a", i_data[0], 32'h0);
        chk("rst_cpu_rstb_a", cpu_rstb[0], 1'b1);
        chk("rst_ld_ready_a", ld_ready[0], 1'b0);
        chk("rst_cpu_rstb_b", cpu_rstb[1], 1'b0);
        chk("rst_ld_ready_b", ld_ready[1], 1'b1);
        rstb_a = 1'b1;
        rstb_b = 1'b1;
        cyc(1);

        rd(0, 32'h0001_0000, 32'h0000_0013, "oor_fill");
        ld_valid[0] = 1'b1; ld_byte[0] = 8'hAA; ld_last[0] = 1'b1;
        cyc(1);
        ld_valid[0] = 1'b0; ld_last[0] = 1'b0;
        chk("run_ignores_bytes", 32'(wc_a), 32'd0);

        boot(0);
        chk("boot_holds_cpu", cpu_rstb[0], 1'b0);
        send_word(0, 32'h0000_0513, 1'b0);
        send_word(0, 32'h0010_0593, 1'b1);
        chk("full_rel_1", cpu_rstb[0], 1'b0);
        cyc(1);
        chk("full_rel_2", cpu_rstb[0], 1'b1);
        chk("full_wc", 32'(wc_a), 32'd2);
        chk("model_w0", mmem[0], 32'h0000_0513);
        rd(0, 32'h0, 32'h0000_0513, "ram0");
        rd(0, 32'h4, 32'h0010_0593, "ram1");

        boot(0);
        for (int b = 1; b <= 5; b++) send(0, 8'(b), b == 5);
        chk("part_rel_1", cpu_rstb[0], 1'b0);
        cyc(1);
        chk("part_rel_2", cpu_rstb[0], 1'b0);
        cyc(1);
        chk("part_rel_3", cpu_rstb[0], 1'b1);
        chk("part_wc", 32'(wc_a), 32'd2);
        chk("model_partial", mmem[1], 32'h0000_0005);
        rd(0, 32'h4, 32'h0000_0005, "partial_word");
        rd(0, 32'h0, 32'h0403_0201, "first_word");

        boot(0);
        for (int w = 0; w < 6; w++) begin
            send_word(0, (w == 5) ? 32'hDEAD_BEEF : 32'h0101_0101 * w, w == 5);
            if (w == 2) begin
                boot(0);
                ld_last[0] = 1'b1;
                cyc(1);
                ld_last[0] = 1'b0;
            end
        end
        cyc(2);
        chk("six_wc", 32'(wc_a), 32'd6);
        rd(0, 32'h14, 32'hDEAD_BEEF, "ram5");
        rd(0, 32'h8, 32'h0202_0202, "ram2");

        send_word(1, 32'hCAFE_F00D, 1'b0);
        send(1, 8'h11, 1'b0);
        chk("b_wc_before_rst", 32'(wc_b), 32'd1);
        rstb_b = 1'b0;
        #2;
        chk("b_async_wc", 32'(wc_b), 32'd0);
        cyc(1);
        rstb_b = 1'b1;
        cyc(1);
        chk("b_rel_ready", ld_ready[1], 1'b1);
        chk("b_rel_cpu", cpu_rstb[1], 1'b0);
        boot(1);
        for (int w = 0; w < 5; w++) send_word(1, 32'hA0A0_A0A0 + w, w == 4);
        cyc(2);
        chk("ovf_err", load_err[1], 1'b1);
        chk("ovf_wc", 32'(wc_b), 32'd4);
        for (int w = 0; w < 4; w++) rd(1, 32'(4 * w), 32'hA0A0_A0A0 + w, $sformatf("ovf_ram%0d", w));
        chk("err_sticky", load_err[1], 1'b1);
        boot(1);
        chk("err_cleared", load_err[1], 1'b0);
        send_word(1, 32'h1234_5678, 1'b1);
        cyc(3);
        rd(1, 32'h0, 32'h1234_5678, "reload0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
